aes_inv_key_expansion: RTL and testbench
========================================

AES_INV_KEY_EXPANSION -- requirements
Module: aes_inv_key_expansion

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock.
REQ-002 rst input 1 SHALL be the synchronous active-high reset, sampled on the clk rising edge.
REQ-003 start input 1 SHALL be a one-cycle request to begin a schedule; it is sampled only in IDLE.
REQ-004 key_in input 128 SHALL be the seed key, captured on an accepted start; bits [127:96] are w0.
REQ-005 busy output 1 SHALL be high in every state except IDLE.
REQ-006 rk_valid output 1 SHALL flag that round_key and rk_index are valid.
REQ-007 rk_ready input 1 SHALL be the consumer acceptance; a transfer occurs when rk_valid & rk_ready are both high.
REQ-008 round_key output 128 SHALL be the emitted round key.
REQ-009 rk_index output 4 SHALL be the AES round number of round_key, 10 down to 0.
REQ-010 done output 1 SHALL pulse for one cycle after index 0 is transferred.

Function
REQ-011 States SHALL be IDLE, FWD (only when macro enabled) and EMIT.
REQ-012 In IDLE, start=1 SHALL capture key_in into curr_key and move to EMIT (or FWD), setting rnum=10.
REQ-013 In EMIT, rk_valid SHALL be 1, with round_key=curr_key and rk_index=rnum.
REQ-014 Inverse step: w3p=w3^w2, w2p=w2^w1, w1p=w1^w0, w0p=w0^SubWord(RotWord(w3p))^{RCON[rnum],24'h0}.
REQ-015 RotWord SHALL be {b1,b2,b3,b0} of w3p; RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36.
REQ-016 On a transfer with rnum>0, curr_key SHALL take {w0p,w1p,w2p,w3p} and rnum SHALL decrement, so the next key is valid the next cycle.
REQ-017 On a transfer with rnum==0, the FSM SHALL go to IDLE, drive rk_valid=0 and pulse done=1 the following cycle.
REQ-018 While rk_valid=1 and rk_ready=0, round_key and rk_index SHALL hold stable.
REQ-019 start outside IDLE SHALL be ignored with no state change; start together with done SHALL be ignored.
REQ-020 First-key latency: rk_valid SHALL go high the cycle after start (macro off); sustained throughput SHALL be one key per cycle with rk_ready held high.
REQ-021 rk_index SHALL never go below 0 or wrap; exactly 11 transfers SHALL occur per start.

Reset
REQ-022 On rst, state=IDLE, rk_valid=0, done=0, busy=0, round_key=0, rk_index=0, rnum=0.
REQ-023 rst during FWD or EMIT SHALL abort immediately with no done pulse; rst SHALL dominate start.

Configuration
REQ-024 Macro AES_INV_KEY_FWD_DERIVE_EN SHALL control the FWD state.
REQ-025 With the macro defined, key_in SHALL be the cipher key (round 0); FWD SHALL run 10 forward-expansion cycles (counter 1..10) and then enter EMIT with the round-10 key; first rk_valid is 11 cycles after start; busy=1 and rk_valid=0 during FWD.
REQ-026 Forward and inverse steps SHALL share the same four S-box instances through an input mux.
REQ-027 With the macro undefined, key_in SHALL be the round-10 key, the FWD state and logic SHALL be absent, and the start-to-EMIT transition SHALL be direct.

Structure
REQ-028 Package aes_pkg SHALL hold the RCON table, the key-width constant (128), the round-count constant (10) and the state enum.
REQ-029 The existing s_box module SHALL be the only sub-module: four instances.

Verification
REQ-030 Macro off: start, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1 -> idx10 = that key, idx9 = ac7766f319fadc2128d12941575c006e, idx1 = a0fafe1788542cb123a339392a6c7605, idx0 = 2b7e151628aed2a6abf7158809cf4f3c, then done pulse.
REQ-031 Backpressure: hold rk_ready=0 for 5 cycles at idx 7 -> round_key and rk_index stay stable; 11 transfers total; the keys match REQ-030.
REQ-032 start asserted during EMIT with a different key_in -> ignored; the sequence completes unchanged.
REQ-033 rst asserted at idx 4 -> next cycle busy=0, rk_valid=0, no done pulse; a new start then produces a full, correct sequence.
REQ-034 Macro on: start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> rk_valid rises 11 cycles later with idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; the remaining keys match REQ-030.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants, round-constant lookup and FSM state encoding.
// Macro AES_INV_KEY_FWD_DERIVE_EN adds the forward-derivation state.
package aes_pkg;

   localparam int KEY_W      = 128;
   localparam int NUM_ROUNDS = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
`ifdef AES_INV_KEY_FWD_DERIVE_EN
      ST_FWD  = 2'd1,
`endif
      ST_EMIT = 2'd2
   } state_t;

   // RCON[1..10]; index 0 is never consumed by a schedule step.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/s_box.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module s_box (
   input  logic [7:0] din_i,
   output logic [7:0] dout_o
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      logic [7:0] c;
      logic [7:0] y;
      c = 8'h63;
      for (int i = 0; i < 8; i++) begin
         y[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
      end
      return y;
   endfunction

   assign dout_o = affine(gf_inv(din_i));

endmodule

// File: rtl/aes_inv_key_expansion.sv
// AES-128 key schedule emitted in reverse order (round 10 down to 0) over a valid/ready port.
// Macro AES_INV_KEY_FWD_DERIVE_EN: seed is the cipher key and rounds 1..10 are derived first.
module aes_inv_key_expansion
   import aes_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [KEY_W-1:0]   key_in,
   output logic               busy,
   output logic               rk_valid,
   input  logic               rk_ready,
   output logic [KEY_W-1:0]   round_key,
   output logic [3:0]         rk_index,
   output logic               done
);

   state_t             state_q, state_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [3:0]         rnum_q, rnum_d;
   logic               done_q, done_d;
`ifdef AES_INV_KEY_FWD_DERIVE_EN
   logic [3:0]         cnt_q, cnt_d;
`endif

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] w0p, w1p, w2p, w3p;
   logic [31:0] sub_in, rot, sub;
   logic [7:0]  rc;
   logic [3:0]  rc_idx;

   assign w0  = key_q[127:96];
   assign w1  = key_q[95:64];
   assign w2  = key_q[63:32];
   assign w3  = key_q[31:0];
   assign w3p = w3 ^ w2;
   assign w2p = w2 ^ w1;
   assign w1p = w1 ^ w0;

   // Forward and inverse steps share one SubWord; only its input word and RCON index differ.
`ifdef AES_INV_KEY_FWD_DERIVE_EN
   assign sub_in = (state_q == ST_FWD) ? w3 : w3p;
   assign rc_idx = (state_q == ST_FWD) ? cnt_q : rnum_q;
`else
   assign sub_in = w3p;
   assign rc_idx = rnum_q;
`endif
   assign rot = {sub_in[23:0], sub_in[31:24]};
   assign rc  = rcon(rc_idx);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      s_box u_s_box (
         .din_i  (rot[8*g +: 8]),
         .dout_o (sub[8*g +: 8])
      );
   end

   assign w0p = w0 ^ sub ^ {rc, 24'h0};

`ifdef AES_INV_KEY_FWD_DERIVE_EN
   logic [31:0] f0, f1, f2, f3;
   assign f0 = w0 ^ sub ^ {rc, 24'h0};
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;
`endif

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      rnum_d  = rnum_q;
      done_d  = 1'b0;
`ifdef AES_INV_KEY_FWD_DERIVE_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // A start landing on the done cycle is deliberately dropped.
            if (start && !done_q) begin
               key_d  = key_in;
               rnum_d = 4'(NUM_ROUNDS);
`ifdef AES_INV_KEY_FWD_DERIVE_EN
               cnt_d   = 4'd1;
               state_d = ST_FWD;
`else
               state_d = ST_EMIT;
`endif
            end
         end
`ifdef AES_INV_KEY_FWD_DERIVE_EN
         ST_FWD: begin
            key_d = {f0, f1, f2, f3};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(NUM_ROUNDS)) state_d = ST_EMIT;
         end
`endif
         ST_EMIT: begin
            if (rk_ready) begin
               if (rnum_q != 4'd0) begin
                  key_d  = {w0p, w1p, w2p, w3p};
                  rnum_d = rnum_q - 4'd1;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         rnum_q  <= '0;
         done_q  <= 1'b0;
`ifdef AES_INV_KEY_FWD_DERIVE_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         rnum_q  <= rnum_d;
         done_q  <= done_d;
`ifdef AES_INV_KEY_FWD_DERIVE_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign rk_valid  = (state_q == ST_EMIT);
   assign round_key = key_q;
   assign rk_index  = rnum_q;
   assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Directed bench for aes_inv_key_expansion using the FIPS-197 example key schedule.
module tb_aes_inv_key_expansion;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] round_key;
   logic [3:0]   rk_index;
   logic         done;

   logic [127:0] expk [0:10];
   logic [127:0] seed;
   int           tests = 0;
   int           fails = 0;

`ifdef AES_INV_KEY_FWD_DERIVE_EN
   localparam int FWD_CYC = 10;
`else
   localparam int FWD_CYC = 0;
`endif

   always #5 clk = ~clk;

   aes_inv_key_expansion dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .busy      (busy),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .round_key (round_key),
      .rk_index  (rk_index),
      .done      (done)
   );

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 || round_key !== '0 || rk_index !== 4'd0) begin
         fails++;
         $display("FAIL reset_state busy=%b vld=%b done=%b key=%h idx=%0d required all zero",
                  busy, rk_valid, done, round_key, rk_index);
      end
      rst = 1'b0;
   endtask

   task automatic test_sequence;
      int wt;
      @(posedge clk); #1;
      key_in = seed; start = 1'b1; rk_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wt = 0;
      while (!rk_valid && wt < 40) begin
         tests++;
         if (busy !== 1'b1) begin fails++; $display("FAIL seq_busy_fwd busy=%b required 1", busy); end
         @(posedge clk); #1;
         wt++;
      end
      tests++;
      if (wt != FWD_CYC) begin fails++; $display("FAIL seq_latency waited=%0d required %0d", wt, FWD_CYC); end
      for (int i = 10; i >= 0; i--) begin
         tests++;
         if (rk_valid !== 1'b1 || busy !== 1'b1 || rk_index !== 4'(i) || round_key !== expk[i]) begin
            fails++;
            $display("FAIL seq_key vld=%b idx=%0d key=%h required idx=%0d key=%h",
                     rk_valid, rk_index, round_key, i, expk[i]);
         end
         @(posedge clk); #1;
      end
      tests++;
      if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL seq_done done=%b vld=%b busy=%b required 1/0/0", done, rk_valid, busy);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL seq_done_width done=%b required 0", done); end
   endtask

   task automatic test_backpressure;
      int wt, exp_idx, stall, xfers, cyc;
      @(posedge clk); #1;
      key_in = seed; start = 1'b1; rk_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wt = 0;
      while (!rk_valid && wt < 40) begin @(posedge clk); #1; wt++; end
      exp_idx = 10; stall = 0; xfers = 0; cyc = 0;
      while (xfers < 11 && cyc < 60) begin
         tests++;
         if (rk_valid !== 1'b1 || rk_index !== 4'(exp_idx) || round_key !== expk[exp_idx]) begin
            fails++;
            $display("FAIL bp_key vld=%b idx=%0d key=%h required idx=%0d key=%h stall=%0d",
                     rk_valid, rk_index, round_key, exp_idx, expk[exp_idx], stall);
         end
         if (exp_idx == 7 && stall < 5) begin
            rk_ready = 1'b0;
            stall++;
         end else begin
            rk_ready = 1'b1;
            xfers++;
            exp_idx--;
         end
         @(posedge clk); #1;
         cyc++;
      end
      rk_ready = 1'b1;
      tests++;
      if (xfers != 11 || stall != 5 || done !== 1'b1) begin
         fails++;
         $display("FAIL bp_count xfers=%0d stall=%0d done=%b required 11/5/1", xfers, stall, done);
      end
   endtask

   task automatic test_start_ignored;
      int wt;
      @(posedge clk); #1;
      key_in = seed; start = 1'b1; rk_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wt = 0;
      while (!rk_valid && wt < 40) begin @(posedge clk); #1; wt++; end
      for (int i = 10; i >= 0; i--) begin
         tests++;
         if (rk_valid !== 1'b1 || rk_index !== 4'(i) || round_key !== expk[i]) begin
            fails++;
            $display("FAIL ign_key idx=%0d key=%h required idx=%0d key=%h", rk_index, round_key, i, expk[i]);
         end
         start  = (i == 8);
         key_in = (i == 8) ? ~seed : seed;
         @(posedge clk); #1;
      end
      start = 1'b0;
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL ign_done done=%b required 1", done); end
   endtask

   task automatic test_start_with_done;
      int wt;
      @(posedge clk); #1;
      key_in = seed; start = 1'b1; rk_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wt = 0;
      while (!done && wt < 60) begin @(posedge clk); #1; wt++; end
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL swd_reach_done done=%b required 1", done); end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (busy !== 1'b0 || rk_valid !== 1'b0) begin
         fails++;
         $display("FAIL swd_ignored busy=%b vld=%b required 0/0", busy, rk_valid);
      end
   endtask

   task automatic test_reset_abort;
      int wt;
      @(posedge clk); #1;
      key_in = seed; start = 1'b1; rk_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wt = 0;
      while (!(rk_valid && rk_index == 4'd4) && wt < 60) begin @(posedge clk); #1; wt++; end
      tests++;
      if (rk_index !== 4'd4 || round_key !== expk[4]) begin
         fails++;
         $display("FAIL abort_reach idx=%0d key=%h required 4 %h", rk_index, round_key, expk[4]);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests++;
      if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 || rk_index !== 4'd0 || round_key !== '0) begin
         fails++;
         $display("FAIL abort_state busy=%b vld=%b done=%b idx=%0d key=%h required all zero",
                  busy, rk_valid, done, rk_index, round_key);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done done=%b busy=%b required 0/0", done, busy);
         end
      end
      key_in = seed; rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      tests++;
      if (busy !== 1'b0 || rk_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_over_start busy=%b vld=%b required 0/0", busy, rk_valid);
      end
   endtask

   initial begin
      expk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      expk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      expk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      expk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      expk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      expk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      expk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      expk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      expk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      expk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      expk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_INV_KEY_FWD_DERIVE_EN
      seed = expk[0];
`else
      seed = expk[10];
`endif
      test_reset();
      test_sequence();
      test_backpressure();
      test_start_ignored();
      test_start_with_done();
      test_reset_abort();
      test_sequence();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
